// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int AW_DEF      = 16;
   localparam int DW_DEF      = 32;
   localparam int TIMEOUT_DEF = 255;

   // Data returned to a requester whose read was abandoned by the timeout.
   localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {IDLE, WR0, WR1, RD0, RD1} arb_state_e;

   // Two-way round robin: on a tie the port that did not win last time goes.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      return (req == 2'b11) ? ~last : req[1];
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter: one shared read/write channel.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          m_rd_en;
   logic          m_wr_en;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wr_data;
   logic [DW-1:0] m_rd_data;
   logic          m_rd_valid;

   modport master (
      output m_rd_en, m_wr_en, m_addr, m_wr_data,
      input  m_rd_data, m_rd_valid
   );

   modport slave (
      input  m_rd_en, m_wr_en, m_addr, m_wr_data,
      output m_rd_data, m_rd_valid
   );
endinterface

// File: rtl/mem_arbiter_wr_buf.sv
// One-entry posted write buffer for a single requester port.
module wr_buf #(
   parameter int AW = 16,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          drain,
   output logic          full,
   output logic [AW-1:0] buf_addr,
   output logic [DW-1:0] buf_data,
   output logic          drop
);

   // A write lands if the slot is free or is being emptied on this same edge.
   logic take;
   assign take = wr_en && (!full || drain);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full     <= 1'b0;
         buf_addr <= '0;
         buf_data <= '0;
         drop     <= 1'b0;
      end else begin
         if (take) begin
            full     <= 1'b1;
            buf_addr <= wr_addr;
            buf_data <= wr_data;
         end else if (drain) begin
            full <= 1'b0;
         end
         if (wr_en && !take)
            drop <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU, DMA) onto one memory channel, with posted writes
// that are always drained ahead of any read, and a per-read timeout.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          p0_rd_en,
   input  logic          p0_wr_en,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wr_data,
   output logic [DW-1:0] p0_rd_data,
   output logic          p0_rd_valid,
   output logic          p0_wb_full,

   input  logic          p1_rd_en,
   input  logic          p1_wr_en,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wr_data,
   output logic [DW-1:0] p1_rd_data,
   output logic          p1_rd_valid,
   output logic          p1_wb_full,

   output logic [1:0]    err_drop,
   output logic [1:0]    err_timeout,

   mem_arbiter_if.master mem
);

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

   logic [1:0]          rd_en, wr_en, full, drain, rd_valid, to_set;
   logic [1:0][AW-1:0]  addr, buf_addr;
   logic [1:0][DW-1:0]  wdata, buf_data, rd_data;

   arb_state_e state, state_nx;
   logic       last_grant, lg_nx;
   logic [7:0] cnt, cnt_nx;
   logic       gp;

   assign rd_en = {p1_rd_en, p0_rd_en};
   assign wr_en = {p1_wr_en, p0_wr_en};
   assign addr  = {p1_addr, p0_addr};
   assign wdata = {p1_wr_data, p0_wr_data};

   generate
      for (genvar i = 0; i < 2; i++) begin : g_wb
         wr_buf #(.AW(AW), .DW(DW)) u_wb (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[i]),
            .wr_addr  (addr[i]),
            .wr_data  (wdata[i]),
            .drain    (drain[i]),
            .full     (full[i]),
            .buf_addr (buf_addr[i]),
            .buf_data (buf_data[i]),
            .drop     (err_drop[i])
         );
      end
   endgenerate

   // The state itself is the registered grant; gp is the granted port.
   assign gp = (state == WR1) || (state == RD1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         cnt         <= '0;
         err_timeout <= '0;
      end else begin
         state       <= state_nx;
         last_grant  <= lg_nx;
         cnt         <= cnt_nx;
         err_timeout <= err_timeout | to_set;
      end
   end

   always_comb begin
      state_nx      = state;
      lg_nx         = last_grant;
      cnt_nx        = cnt;
      to_set        = '0;
      drain         = '0;
      rd_valid      = '0;
      rd_data       = '0;
      mem.m_rd_en   = 1'b0;
      mem.m_wr_en   = 1'b0;
      mem.m_addr    = '0;
      mem.m_wr_data = '0;

      case (state)
         IDLE: begin
            // A write arriving this cycle also holds reads off, so a read
            // issued alongside its own write still sees that write.
            if (|full)
               state_nx = rr_pick(full, last_grant) ? WR1 : WR0;
            else if ((|rd_en) && !(|wr_en)) begin
               state_nx = rr_pick(rd_en, last_grant) ? RD1 : RD0;
               cnt_nx   = '0;
            end
         end

         WR0, WR1: begin
            drain[gp]     = 1'b1;
            mem.m_wr_en   = 1'b1;
            mem.m_addr    = buf_addr[gp];
            mem.m_wr_data = buf_data[gp];
            lg_nx         = gp;
            state_nx      = IDLE;
         end

         RD0, RD1: begin
            // A withdrawn request is dropped at once; nothing more is
            // issued to memory and a late response goes nowhere.
            if (!rd_en[gp])
               state_nx = IDLE;
            else begin
               mem.m_rd_en = 1'b1;
               mem.m_addr  = addr[gp];
               if (mem.m_rd_valid) begin
                  rd_valid[gp] = 1'b1;
                  rd_data[gp]  = mem.m_rd_data;
                  lg_nx        = gp;
                  state_nx     = IDLE;
               end else if (cnt == TO_LIM) begin
                  rd_valid[gp] = 1'b1;
                  rd_data[gp]  = DW'(TIMEOUT_DATA);
                  to_set[gp]   = 1'b1;
                  lg_nx        = gp;
                  state_nx     = IDLE;
               end else
                  cnt_nx = cnt + 8'd1;
            end
         end

         default: state_nx = IDLE;
      endcase
   end

   assign p0_rd_data  = rd_data[0];
   assign p0_rd_valid = rd_valid[0];
   assign p0_wb_full  = full[0];
   assign p1_rd_data  = rd_data[1];
   assign p1_rd_valid = rd_valid[1];
   assign p1_wb_full  = full[1];

endmodule
